// File: rtl/data_mem_responder_if.sv
// Load/store bus between the pipeline (master) and the data memory (slave).
interface data_mem_responder_if;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [2:0]  func3;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busywait;
    logic        misaligned;

    modport master (
        output read, write, address, func3, writedata,
        input  readdata, busywait, misaligned
    );

    modport slave (
        input  read, write, address, func3, writedata,
        output readdata, busywait, misaligned
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory with fixed access latency and a BUSYWAIT stall
// handshake. Byte/halfword/word stores merge into the addressed lanes; loads
// return the addressed byte/halfword right-justified and zero-padded.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    data_mem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [AW+1:0]   r_addr;
    logic [1:0]      r_size;
    logic [31:0]     r_wdata;
    logic            r_is_store;
    logic [31:0]     r_rdata;
    logic            r_mis;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_req;
    logic            w_illegal;
    logic            w_busy;
    logic            w_last;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_word;
    logic [31:0]     w_shift_b;
    logic [31:0]     w_shift_h;
    logic [31:0]     w_load;
    logic [3:0]      w_be;
    logic [31:0]     w_wmerge;
    logic            w_unused_addr;

    // Rejects misaligned halfword/word accesses, reserved func3 codes and
    // stores that use the load-only unsigned encodings.
    function automatic logic f_illegal(input logic [2:0] f3,
                                       input logic [1:0] a,
                                       input logic       st);
        logic bad;
        case (f3)
            3'b000:         bad = 1'b0;
            3'b001:         bad = a[0];
            3'b010:         bad = (a != 2'b00);
            3'b100, 3'b101: bad = st;
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign w_req         = bus.read | bus.write;
    assign w_illegal     = f_illegal(bus.func3, bus.address[1:0], bus.write);
    assign w_last        = (r_cnt == {CW{1'b0}});
    assign w_unused_addr = &{1'b0, bus.address[31:AW+2]};

    // Next-state logic of the access FSM.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_illegal) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_ACCESS;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_ACCESS;
                end
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Stall request: follows the request in IDLE, held through ACCESS,
    // released in DONE and forced low while reset is asserted.
    always_comb begin
        w_busy = 1'b0;
        if (i_rst) begin
            w_busy = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE:   w_busy = w_req;
                ST_ACCESS: w_busy = 1'b1;
                ST_DONE:   w_busy = 1'b0;
                default:   w_busy = 1'b0;
            endcase
        end
    end

    // Load formatting and store lane merging from the latched request.
    always_comb begin
        w_idx     = r_addr[AW+1:2];
        w_word    = r_mem[w_idx];
        w_shift_b = w_word >> {r_addr[1:0], 3'b000};
        w_shift_h = w_word >> {r_addr[1], 4'b0000};
        w_load    = w_word;
        w_be      = 4'b1111;
        w_wmerge  = r_wdata;
        case (r_size)
            2'b00: begin
                w_load   = {24'h000000, w_shift_b[7:0]};
                w_be     = 4'b0001 << r_addr[1:0];
                w_wmerge = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_load   = {16'h0000, w_shift_h[15:0]};
                w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wmerge = {2{r_wdata[15:0]}};
            end
            default: begin
                w_load   = w_word;
                w_be     = 4'b1111;
                w_wmerge = r_wdata;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch, latency counter and registered response.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt      <= {CW{1'b0}};
            r_addr     <= {(AW+2){1'b0}};
            r_size     <= 2'b00;
            r_wdata    <= 32'h00000000;
            r_is_store <= 1'b0;
            r_rdata    <= 32'h00000000;
            r_mis      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req && w_illegal) begin
                        r_mis   <= 1'b1;
                        r_rdata <= 32'h00000000;
                    end else if (w_req) begin
                        r_addr     <= bus.address[AW+1:0];
                        r_size     <= bus.func3[1:0];
                        r_wdata    <= bus.writedata;
                        r_is_store <= bus.write;
                        r_cnt      <= CW'(LATENCY - 1);
                    end
                end
                ST_ACCESS: begin
                    if (w_last) begin
                        if (!r_is_store) begin
                            r_rdata <= w_load;
                        end
                    end else begin
                        r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: r_mis <= 1'b0;
                default: r_mis <= 1'b0;
            endcase
        end
    end

    // Memory array: cleared on reset, lane-merged store on the final
    // access cycle so an aborted store never lands.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= 32'h00000000;
            end
        end else if ((r_state == ST_ACCESS) && w_last && r_is_store) begin
            for (int l = 0; l < 4; l++) begin
                if (w_be[l]) begin
                    r_mem[w_idx][8*l +: 8] <= w_wmerge[8*l +: 8];
                end
            end
        end
    end

    assign bus.readdata   = r_rdata;
    assign bus.misaligned = r_mis;
    assign bus.busywait   = w_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (LATENCY=4).
module tb_data_mem_responder;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] rdat;
    logic        mis;

    data_mem_responder_if bus ();

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction; entered and left at posedge+1 in IDLE.
    task automatic acc(input string tag, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, input int exp_cycles,
                       output logic [31:0] rd_o, output logic mis_o);
        int n;
        bus.read      = rd;
        bus.write     = wr;
        bus.address   = a;
        bus.func3     = f3;
        bus.writedata = wd;
        #1;
        chk({tag, " busy_req"}, {31'd0, bus.busywait}, 32'd1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.busywait === 1'b1 && n < 20);
        chk({tag, " stall"}, n, exp_cycles);
        rd_o  = bus.readdata;
        mis_o = bus.misaligned;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        @(posedge clk); #1;
        chk({tag, " mis_clr"}, {31'd0, bus.misaligned}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.read      = 1'b1;
        bus.write     = 1'b0;
        bus.address   = 32'h00000000;
        bus.func3     = 3'b010;
        bus.writedata = 32'h00000000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", {31'd0, bus.busywait}, 32'd0);
        chk("rst rdata", bus.readdata, 32'h00000000);
        chk("rst mis", {31'd0, bus.misaligned}, 32'd0);
        bus.read = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Word store then load.
        acc("sw10", 1'b0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 5, rdat, mis);
        chk("sw10 mis", {31'd0, mis}, 32'd0);
        acc("lw10", 1'b1, 1'b0, 32'h10, 3'b010, 32'h0, 5, rdat, mis);
        chk("lw10 data", rdat, 32'hDEADBEEF);

        // Byte store into lane 3; store leaves READDATA unchanged.
        acc("sb13", 1'b0, 1'b1, 32'h13, 3'b000, 32'h123456AA, 5, rdat, mis);
        chk("sb13 rdata_kept", rdat, 32'hDEADBEEF);
        acc("lw10b", 1'b1, 1'b0, 32'h10, 3'b010, 32'h0, 5, rdat, mis);
        chk("lw10b data", rdat, 32'hAAADBEEF);
        acc("lb13", 1'b1, 1'b0, 32'h13, 3'b000, 32'h0, 5, rdat, mis);
        chk("lb13 data", rdat, 32'h000000AA);
        acc("lbu11", 1'b1, 1'b0, 32'h11, 3'b100, 32'h0, 5, rdat, mis);
        chk("lbu11 data", rdat, 32'h000000BE);
        acc("lhu12", 1'b1, 1'b0, 32'h12, 3'b101, 32'h0, 5, rdat, mis);
        chk("lhu12 data", rdat, 32'h0000AAAD);

        // Halfword store into upper half.
        acc("sh22", 1'b0, 1'b1, 32'h22, 3'b001, 32'h0000CAFE, 5, rdat, mis);
        acc("lhu22", 1'b1, 1'b0, 32'h22, 3'b101, 32'h0, 5, rdat, mis);
        chk("lhu22 data", rdat, 32'h0000CAFE);
        acc("lw20", 1'b1, 1'b0, 32'h20, 3'b010, 32'h0, 5, rdat, mis);
        chk("lw20 data", rdat, 32'hCAFE0000);

        // Illegal accesses: one-cycle stall, MISALIGNED, READDATA zeroed.
        acc("lh21", 1'b1, 1'b0, 32'h21, 3'b001, 32'h0, 1, rdat, mis);
        chk("lh21 mis", {31'd0, mis}, 32'd1);
        chk("lh21 rdata", rdat, 32'h00000000);
        acc("sw12", 1'b0, 1'b1, 32'h12, 3'b010, 32'h99999999, 1, rdat, mis);
        chk("sw12 mis", {31'd0, mis}, 32'd1);
        acc("lw10c", 1'b1, 1'b0, 32'h10, 3'b010, 32'h0, 5, rdat, mis);
        chk("lw10c data", rdat, 32'hAAADBEEF);
        acc("f3_011", 1'b1, 1'b0, 32'h10, 3'b011, 32'h0, 1, rdat, mis);
        chk("f3_011 mis", {31'd0, mis}, 32'd1);
        acc("sbu", 1'b0, 1'b1, 32'h10, 3'b100, 32'h77, 1, rdat, mis);
        chk("sbu mis", {31'd0, mis}, 32'd1);
        acc("lw10d", 1'b1, 1'b0, 32'h10, 3'b010, 32'h0, 5, rdat, mis);
        chk("lw10d data", rdat, 32'hAAADBEEF);

        // READ and WRITE together: store wins.
        acc("rw30", 1'b1, 1'b1, 32'h30, 3'b010, 32'h11111111, 5, rdat, mis);
        chk("rw30 rdata_kept", rdat, 32'hAAADBEEF);
        acc("lw30", 1'b1, 1'b0, 32'h30, 3'b010, 32'h0, 5, rdat, mis);
        chk("lw30 data", rdat, 32'h11111111);

        // Reset during ACCESS cycle 2 aborts the store.
        bus.read      = 1'b0;
        bus.write     = 1'b1;
        bus.address   = 32'h40;
        bus.func3     = 3'b010;
        bus.writedata = 32'h55555555;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort busy_pre", {31'd0, bus.busywait}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort busy_rst", {31'd0, bus.busywait}, 32'd0);
        chk("abort rdata", bus.readdata, 32'h00000000);
        bus.write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        acc("lw40", 1'b1, 1'b0, 32'h40, 3'b010, 32'h0, 5, rdat, mis);
        chk("lw40 data", rdat, 32'h00000000);
        acc("lw30r", 1'b1, 1'b0, 32'h30, 3'b010, 32'h0, 5, rdat, mis);
        chk("lw30r cleared", rdat, 32'h00000000);
        acc("sw44", 1'b0, 1'b1, 32'h44, 3'b010, 32'h0BADF00D, 5, rdat, mis);
        acc("lw44", 1'b1, 1'b0, 32'h44, 3'b010, 32'h0, 5, rdat, mis);
        chk("lw44 data", rdat, 32'h0BADF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-organised data memory that sits at the far end of the load/store path. It accepts byte, halfword and word stores, merging each into the addressed byte lanes. For loads it returns the addressed byte or halfword right-justified and zero-padded, so the load-formatting stage downstream only has to sign- or zero-extend from bit 0. It uses a fixed multi-cycle latency and signals progress to the pipeline with a BUSYWAIT handshake, which stalls the pipeline until the access completes.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two; index = ADDRESS[log2(DEPTH_WORDS)+1:2], upper bits ignored.
- LATENCY, 4: access cycles, ≥1.
- CLK  input  1  single clock, rising edge.
- RESET  input  1  asynchronous, active-high.
- READ  input  1  load request.
- WRITE  input  1  store request; wins if READ also high.
- ADDRESS  input  32  byte address.
- func3  input  3  RISC-V funct3: 000 byte, 001 half, 010 word, 100 byte-unsigned (load only), 101 half-unsigned (load only).
- WRITEDATA  input  32  store data, lower bits significant per size.
- READDATA  output  32  right-justified load data, zero-padded.
- BUSYWAIT  output  1  stall request to pipeline.
- MISALIGNED  output  1  access rejected (alignment or illegal func3).

## Operation
- States IDLE, ACCESS, DONE.
- IDLE: BUSYWAIT = READ|WRITE (combinational). At posedge with a request:
  - legal: latch ADDRESS, func3, WRITEDATA, op; counter ← LATENCY-1; → ACCESS.
  - illegal: → DONE with MISALIGNED←1, READDATA←0; no memory change.
- Illegal means any of:
  - half with ADDRESS[0]=1;
  - word with ADDRESS[1:0]≠00;
  - func3 ∈ {011,110,111};
  - store with func3 ∈ {100,101}.
- ACCESS: BUSYWAIT=1. Counter decrements each posedge. At the posedge where counter==0:
  - store, byte: WRITEDATA[7:0] → lane ADDRESS[1:0].
  - store, half: WRITEDATA[15:0] → lanes {ADDRESS[1],0} and {ADDRESS[1],1}.
  - store, word: all lanes.
  - load, byte: READDATA ← {24'b0, byte at lane ADDRESS[1:0]}.
  - load, half: READDATA ← {16'b0, half at ADDRESS[1]}.
  - load, word: READDATA ← full word.
  - store: READDATA unchanged.
  - then → DONE.
- Lanes not addressed are untouched.
- DONE: BUSYWAIT=0 for exactly one cycle; READDATA and MISALIGNED valid. Next posedge → IDLE; MISALIGNED←0. Requests present in DONE are ignored. The pipeline advances during DONE and drops or changes READ/WRITE.

## Timing
- Request sampled at posedge k → BUSYWAIT low and READDATA valid in the cycle after posedge k+LATENCY.
- Total stall = LATENCY+1 cycles including the request cycle.
- Illegal request sampled at k → DONE after posedge k; 1-cycle stall.
- Back-to-back: earliest next request sampled at posedge k+LATENCY+2 (IDLE again).
- RESET high, asynchronous:
  - state→IDLE; READDATA=0; MISALIGNED=0; all memory words cleared to 0.
  - BUSYWAIT forced 0 while RESET is high.
  - An in-flight store aborted by reset is not performed.
- Request inputs must be held stable while BUSYWAIT=1. Changes in ACCESS have no effect because values are latched.

## Test plan
- Reset, then LATENCY=4: sw 0xDEADBEEF @0x10 → BUSYWAIT high 5 cycles, then low 1 cycle; lw @0x10 → READDATA=0xDEADBEEF.
- sb 0x1234_56AA @0x13 over word 0xDEADBEEF → lw @0x10 = 0xAAADBEEF. Then lb @0x13 → READDATA=0x000000AA.
- sh 0x0000CAFE @0x22, then lhu @0x22 → 0x0000CAFE. lw @0x20 = 0xCAFE0000.
- lh @0x21 → MISALIGNED=1 and BUSYWAIT low after 1 cycle; READDATA=0; memory unchanged. sw @0x12 → same, and word @0x10 unchanged.
- READ and WRITE both high, sw 0x11111111 @0x30 → store performed; lw @0x30 = 0x11111111.
- sw 0x55555555 @0x40 with RESET pulsed at ACCESS cycle 2 → BUSYWAIT drops immediately; lw @0x40 = 0x00000000; FSM accepts the next request normally.
